// File: rtl/uart_frame_pkg.sv
// Shared types and helpers for the UART coordinate deframer.
package uart_frame_pkg;

    typedef enum logic [1:0] {
        StHunt,
        StPayload,
        StCheck,
        StCommit
    } deframe_state_t;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hFF;

    function automatic int unsigned payload_bytes(input int unsigned nch, input int unsigned w);
        return (nch * w + 7) / 8;
    endfunction

endpackage

// File: rtl/frame_gap_timer.sv
// Idle-cycle counter for in-frame gaps; emits a 1-cycle pulse when the gap reaches TIMEOUT_CYC.
module frame_gap_timer #(
    parameter int unsigned TIMEOUT_CYC = 65000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic enable_i,
    input  logic clear_i,
    output logic expired_o
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign expired_o = enable_i && (cnt_q == CntW'(TIMEOUT_CYC));

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (!enable_i || clear_i || expired_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_coord_deframer.sv
// Deframes sync-headed, XOR-checked coordinate packets from a UART byte stream.
module uart_coord_deframer
    import uart_frame_pkg::*;
#(
    parameter int unsigned NUM_CH      = 2,
    parameter int unsigned CH_WIDTH    = 12,
    parameter logic [7:0]  SYNC_BYTE   = DEFAULT_SYNC_BYTE,
    parameter int unsigned SYNC_LEN    = 2,
    parameter int unsigned TIMEOUT_CYC = 65000,
    parameter bit          CHECKSUM_EN = 1'b1
) (
    input  logic                       clk_in,
    input  logic                       rst_in_n,
    input  logic [7:0]                 byte_in,
    input  logic                       byte_valid_in,
    output logic [NUM_CH*CH_WIDTH-1:0] coords_out,
    output logic                       valid_out,
    output logic                       frame_err_out,
    output logic                       timeout_out,
    output logic [7:0]                 err_count_out,
    output logic [15:0]                frame_count_out
);

    localparam int unsigned PayloadBytes = payload_bytes(NUM_CH, CH_WIDTH);
    localparam int unsigned CoordW       = NUM_CH * CH_WIDTH;
    localparam int unsigned ShW          = PayloadBytes * 8;
    localparam int unsigned IdxW         = $clog2(PayloadBytes + 1);

    deframe_state_t    state_q;
    logic [2:0]        sync_cnt_q;
    logic [IdxW-1:0]   idx_q;
    logic [7:0]        xor_q;
    logic [ShW-1:0]    shreg_q;
    logic [CoordW-1:0] coords_q;
    logic              valid_q;
    logic              frame_err_q;
    logic              timeout_q;
    logic [7:0]        err_count_q;
    logic [15:0]       frame_count_q;

    logic       gap_expired;
    logic       in_frame;
    logic       hunting;
    logic [2:0] sync_base;
    logic [7:0] err_inc;

    assign in_frame = (state_q == StPayload) || (state_q == StCheck);

    frame_gap_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_gap_timer (
        .clk_i    (clk_in),
        .rst_ni   (rst_in_n),
        .enable_i (in_frame),
        .clear_i  (byte_valid_in),
        .expired_o(gap_expired)
    );

    // A timeout drops back to hunting in the same cycle, so a coincident strobe is
    // evaluated against a fresh (zero) sync count.
    always_comb begin
        hunting   = (state_q == StHunt) || gap_expired;
        sync_base = gap_expired ? 3'd0 : sync_cnt_q;
        err_inc   = (err_count_q == 8'hFF) ? err_count_q : err_count_q + 8'd1;
    end

    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            state_q       <= StHunt;
            sync_cnt_q    <= '0;
            idx_q         <= '0;
            xor_q         <= '0;
            shreg_q       <= '0;
            coords_q      <= '0;
            valid_q       <= 1'b0;
            frame_err_q   <= 1'b0;
            timeout_q     <= 1'b0;
            err_count_q   <= '0;
            frame_count_q <= '0;
        end else begin
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            timeout_q   <= 1'b0;
            if (hunting) begin
                if (gap_expired) begin
                    timeout_q   <= 1'b1;
                    err_count_q <= err_inc;
                    state_q     <= StHunt;
                    sync_cnt_q  <= '0;
                end
                if (byte_valid_in) begin
                    if (byte_in == SYNC_BYTE) begin
                        if (sync_base == 3'(SYNC_LEN - 1)) begin
                            state_q    <= StPayload;
                            sync_cnt_q <= '0;
                            idx_q      <= '0;
                            xor_q      <= '0;
                        end else begin
                            sync_cnt_q <= sync_base + 3'd1;
                        end
                    end else begin
                        sync_cnt_q <= '0;
                    end
                end
            end else begin
                case (state_q)
                    StPayload: begin
                        if (byte_valid_in) begin
                            shreg_q <= ShW'({shreg_q, byte_in});
                            xor_q   <= xor_q ^ byte_in;
                            idx_q   <= idx_q + 1'b1;
                            if (idx_q == IdxW'(PayloadBytes - 1)) begin
                                state_q <= CHECKSUM_EN ? StCheck : StCommit;
                            end
                        end
                    end
                    StCheck: begin
                        if (byte_valid_in) begin
                            if (byte_in == xor_q) begin
                                state_q <= StCommit;
                            end else begin
                                frame_err_q <= 1'b1;
                                err_count_q <= err_inc;
                                state_q     <= StHunt;
                            end
                        end
                    end
                    StCommit: begin
                        // Pad bits sit in the LSBs of the last byte and are dropped here.
                        coords_q      <= shreg_q[ShW-1 -: CoordW];
                        valid_q       <= 1'b1;
                        frame_count_q <= frame_count_q + 16'd1;
                        state_q       <= StHunt;
                    end
                    default: state_q <= StHunt;
                endcase
            end
        end
    end

    assign coords_out      = coords_q;
    assign valid_out       = valid_q;
    assign frame_err_out   = frame_err_q;
    assign timeout_out     = timeout_q;
    assign err_count_out   = err_count_q;
    assign frame_count_out = frame_count_q;

endmodule
